// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants, FSM states and header packing
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      SETUP,
      HDR,
      DATA,
      GAP,
      TAIL
   } state_e;

   localparam int HDR_BITS  = 8;
   localparam int DATA_BITS = 8;

   localparam logic RSV_BIT = 1'b0;

   // Header bit positions, MSB is shifted out first; shared with the slave.
   localparam int HDR_POS_WR   = 7;
   localparam int HDR_POS_EXT0 = 6;
   localparam int HDR_POS_RSV  = 3;
   localparam int HDR_POS_REG0 = 2;

   function automatic logic [7:0] build_header(input logic wr,
                                               input logic [2:0] ext_a,
                                               input logic [2:0] reg_a);
      logic [7:0] h;
      h = '0;
      h[HDR_POS_WR]  = wr;
      h[HDR_POS_RSV] = RSV_BIT;
      for (int i = 0; i < 3; i++) begin
         h[HDR_POS_EXT0 - i] = ext_a[i];
         h[HDR_POS_REG0 - i] = reg_a[i];
      end
      return h;
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host-side request/response bundle of the SPI initiator
interface spi_master_ctrl_if #(
   parameter int MAX_LEN_W = 3
);
   logic                 start;
   logic                 wr;
   logic [2:0]           ext_addr;
   logic [2:0]           reg_addr;
   logic [MAX_LEN_W-1:0] len;
   logic [7:0]           wdata;
   logic                 wdata_take;
   logic [7:0]           rdata;
   logic                 rdata_valid;
   logic                 busy;
   logic                 done;
   logic                 err;

   modport master (
      output start, wr, ext_addr, reg_addr, len, wdata,
      input  wdata_take, rdata, rdata_valid, busy, done, err
   );

   modport slave (
      input  start, wr, ext_addr, reg_addr, len, wdata,
      output wdata_take, rdata, rdata_valid, busy, done, err
   );
endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period tick divider and sclk level with rise/fall strobes
module spi_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic toggle_i,
   output logic tick_o,
   output logic rise_o,
   output logic fall_o,
   output logic sclk_o
);
   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;

   assign tick_o = en_i && (cnt_q == 8'(CLK_DIV - 1));
   assign rise_o = tick_o && toggle_i && !sclk_q;
   assign fall_o = tick_o && toggle_i && sclk_q;
   assign sclk_o = sclk_q;

   // With toggle_i low a tick still marks a half-period but sclk holds its level.
   always_comb begin
      cnt_d  = (!en_i || tick_o) ? 8'd0 : cnt_q + 8'd1;
      sclk_d = (tick_o && toggle_i) ? ~sclk_q : sclk_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= 8'd0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI initiator for the addressed slave register bank
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int MAX_LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   spi_master_ctrl_if.slave host,
   output logic             sclk,
   output logic             cs,
   output logic             mosi,
   input  logic             miso,
   input  logic             miso_oe
);
   state_e               state_q, state_d;
   logic [2:0]           bit_q, bit_d;
   logic [MAX_LEN_W-1:0] len_q, len_d;
   logic                 wr_q, wr_d;
   logic [7:0]           sh_q, sh_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           rdata_q, rdata_d;
   logic                 rv_q, rv_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 frame_q, frame_d;
   logic                 take;
   logic                 gen_en, gen_toggle;
   logic                 tick, rise, fall;
   logic                 miso_bit;

   assign gen_en     = (state_q != IDLE);
   assign gen_toggle = (state_q != TAIL);
   assign miso_bit   = miso & miso_oe;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .en_i     (gen_en),
      .toggle_i (gen_toggle),
      .tick_o   (tick),
      .rise_o   (rise),
      .fall_o   (fall),
      .sclk_o   (sclk)
   );

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      len_d   = len_q;
      wr_d    = wr_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      rv_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      frame_d = frame_q;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (host.start) begin
               wr_d    = host.wr;
               len_d   = host.len;
               sh_d    = build_header(host.wr, host.ext_addr, host.reg_addr);
               bit_d   = 3'd0;
               err_d   = 1'b0;
               frame_d = 1'b1;
               state_d = SETUP;
            end
         end
         FLUSH: begin
            if (fall) begin
               done_d  = frame_q;
               frame_d = 1'b0;
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (rise) state_d = HDR;
         end
         HDR: begin
            // bit_q wraps 7 -> 0, so DATA starts at bit 0 without a reload.
            if (fall) begin
               sh_d  = {sh_q[6:0], 1'b0};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'(HDR_BITS - 1)) begin
                  take    = wr_q;
                  sh_d    = wr_q ? host.wdata : 8'h00;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (fall) begin
               rx_d  = wr_q ? {rx_q[6:0], miso_bit} : {miso_bit, rx_q[7:1]};
               sh_d  = {sh_q[6:0], 1'b0};
               bit_d = bit_q + 3'd1;
               if (!miso_oe) err_d = 1'b1;
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  rdata_d = rx_d;
                  rv_d    = 1'b1;
                  if (len_q != '0) begin
                     len_d   = len_q - MAX_LEN_W'(1);
                     state_d = GAP;
                  end else begin
                     state_d = TAIL;
                  end
               end
            end
         end
         GAP: begin
            if (fall) begin
               take    = wr_q;
               sh_d    = wr_q ? host.wdata : 8'h00;
               state_d = DATA;
            end
         end
         TAIL: begin
            if (tick) state_d = FLUSH;
         end
         default: state_d = FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FLUSH;
         bit_q   <= 3'd0;
         len_q   <= '0;
         wr_q    <= 1'b0;
         sh_q    <= 8'h00;
         rx_q    <= 8'h00;
         rdata_q <= 8'h00;
         rv_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         len_q   <= len_d;
         wr_q    <= wr_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         rv_q    <= rv_d;
         done_q  <= done_d;
         err_q   <= err_d;
         frame_q <= frame_d;
      end
   end

   assign cs   = (state_q != IDLE) && (state_q != FLUSH);
   assign mosi = sh_q[7] && ((state_q == SETUP) || (state_q == HDR) || (state_q == DATA));

   assign host.wdata_take  = take && !rst;
   assign host.rdata       = rdata_q;
   assign host.rdata_valid = rv_q;
   assign host.busy        = (state_q != IDLE);
   assign host.done        = done_q;
   assign host.err         = err_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench with a bit-level slave and a frame-level reference model
module tb_spi_master_ctrl;
   localparam int LW      = 3;
   localparam int CD      = 4;
   localparam int SLV_EXT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int nchk  = 0;
   int nfail = 0;

   spi_master_ctrl_if #(.MAX_LEN_W(LW)) hif ();
   spi_master_ctrl_if #(.MAX_LEN_W(LW)) ha2 ();
   spi_master_ctrl_if #(.MAX_LEN_W(LW)) ha7 ();

   logic sclk, cs, mosi;
   logic miso = 1'b0;
   logic miso_oe;
   logic s2, c2, m2, s7, c7, m7;

   spi_master_ctrl #(.CLK_DIV(CD), .MAX_LEN_W(LW)) u_dut (
      .clk(clk), .rst(rst), .host(hif), .sclk(sclk), .cs(cs), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe));
   spi_master_ctrl #(.CLK_DIV(2), .MAX_LEN_W(LW)) u_dut2 (
      .clk(clk), .rst(rst), .host(ha2), .sclk(s2), .cs(c2), .mosi(m2),
      .miso(1'b0), .miso_oe(1'b0));
   spi_master_ctrl #(.CLK_DIV(7), .MAX_LEN_W(LW)) u_dut7 (
      .clk(clk), .rst(rst), .host(ha7), .sclk(s7), .cs(c7), .mosi(m7),
      .miso(1'b0), .miso_oe(1'b0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit-level slave register bank at ext address SLV_EXT.
   logic [7:0] regs [8];
   logic [7:0] ref_regs [8];
   logic [7:0] hdr = 8'h00, last_hdr = 8'h00, old = 8'h00, nb = 8'h00;
   logic       s_wr = 1'b0, sel = 1'b0;
   logic [2:0] addr = 3'd0;
   int         nbit = 0;
   int         b;

   assign miso_oe = cs && sel;

   always @(posedge sclk) begin
      if (!cs) begin
         nbit = 0;
         sel  = 1'b0;
      end else begin
         if (nbit < 8) begin
            hdr = {hdr[6:0], mosi};
            if (nbit == 7) begin
               last_hdr = hdr;
               s_wr     = hdr[7];
               sel      = ({hdr[4], hdr[5], hdr[6]} == 3'(SLV_EXT));
               addr     = {hdr[0], hdr[1], hdr[2]};
            end
         end else if ((nbit - 8) % 9 == 8) begin
            addr = addr + 3'd1;
         end else if (sel) begin
            b = (nbit - 8) % 9;
            if (b == 0) old = regs[addr];
            miso = s_wr ? old[7 - b] : old[b];
            if (s_wr) begin
               nb = {nb[6:0], mosi};
               if (b == 7) regs[addr] = nb;
            end
         end
         nbit++;
      end
   end

   // Frame monitors
   int         rises_cs = 0, rises_fl = 0, ndone = 0, ntake = 0;
   logic       err_at_done = 1'b0;
   logic       take_pend = 1'b0;
   logic [7:0] rvq [$];
   logic [7:0] wq [8];
   logic [2:0] widx = 3'd0;

   assign hif.wdata = wq[widx];

   always @(posedge sclk) begin
      if (cs) rises_cs++;
      else    rises_fl++;
   end

   always @(negedge clk) begin
      if (take_pend) begin
         widx      = widx + 3'd1;
         take_pend = 1'b0;
      end
      if (hif.wdata_take) begin
         take_pend = 1'b1;
         ntake++;
      end
      if (hif.rdata_valid) rvq.push_back(hif.rdata);
      if (hif.done) begin
         ndone++;
         err_at_done = hif.err;
      end
   end

   // Half-period measurement on the CLK_DIV=2 and CLK_DIV=7 instances.
   time last2 = 0, last7 = 0;
   bit  have2 = 1'b0, have7 = 1'b0;
   int  min2 = 999, max2 = 0, min7 = 999, max7 = 0;

   always @(s2) begin
      if (c2) begin
         if (have2) begin
            if (int'(($time - last2) / 10) < min2) min2 = int'(($time - last2) / 10);
            if (int'(($time - last2) / 10) > max2) max2 = int'(($time - last2) / 10);
         end
         have2 = 1'b1;
         last2 = $time;
      end else have2 = 1'b0;
   end

   always @(s7) begin
      if (c7) begin
         if (have7) begin
            if (int'(($time - last7) / 10) < min7) min7 = int'(($time - last7) / 10);
            if (int'(($time - last7) / 10) > max7) max7 = int'(($time - last7) / 10);
         end
         have7 = 1'b1;
         last7 = $time;
      end else have7 = 1'b0;
   end

   task automatic clear_mon();
      rises_cs = 0;
      rises_fl = 0;
      ndone    = 0;
      ntake    = 0;
      widx     = 3'd0;
      rvq.delete();
   endtask

   // Runs one frame and checks it against the frame-level model; wq holds write bytes.
   task automatic do_frame(input bit w, input bit [2:0] e, input bit [2:0] r,
                           input int n, input bit mid);
      logic [7:0] exp_rd [$];
      logic [7:0] exp_hdr;
      bit         present;
      bit         fired;
      int         a;
      present = (e == 3'(SLV_EXT));
      exp_hdr = {w, e[0], e[1], e[2], 1'b0, r[0], r[1], r[2]};
      for (int k = 0; k <= n; k++) begin
         a = (int'(r) + k) % 8;
         exp_rd.push_back(present ? ref_regs[a] : 8'h00);
         if (w && present) ref_regs[a] = wq[k];
      end
      clear_mon();
      fired = 1'b0;
      @(negedge clk);
      hif.wr       = w;
      hif.ext_addr = e;
      hif.reg_addr = r;
      hif.len      = LW'(n);
      hif.start    = 1'b1;
      for (int i = 0; i < 20000 && ndone == 0; i++) begin
         @(negedge clk);
         hif.start = 1'b0;
         if (mid && !fired && rises_cs >= 10) begin
            fired        = 1'b1;
            hif.start    = 1'b1;
            hif.wr       = ~w;
            hif.ext_addr = e + 3'd1;
            hif.reg_addr = r + 3'd2;
            hif.len      = '0;
         end
      end
      hif.start = 1'b0;
      chk("done", ndone, 1);
      chk("busy_after", hif.busy, 0);
      chk("frame_rises", rises_cs, 16 + 9 * n);
      chk("flush_rises", rises_fl, 1);
      chk("header", last_hdr, exp_hdr);
      chk("n_rdata_valid", rvq.size(), n + 1);
      for (int k = 0; k <= n; k++)
         chk("rdata", (k < rvq.size()) ? {24'h0, rvq[k]} : 32'hFFFF_FFFF, exp_rd[k]);
      chk("err", err_at_done, !present);
      chk("n_wdata_take", ntake, w ? n + 1 : 0);
      for (int k = 0; k < 8; k++) chk("slave_reg", regs[k], ref_regs[k]);
   endtask

   initial begin
      hif.start = 1'b0; hif.wr = 1'b0; hif.ext_addr = '0; hif.reg_addr = '0; hif.len = '0;
      ha2.start = 1'b0; ha2.wr = 1'b0; ha2.ext_addr = '0; ha2.reg_addr = '0; ha2.len = '0;
      ha2.wdata = '0;
      ha7.start = 1'b0; ha7.wr = 1'b0; ha7.ext_addr = '0; ha7.reg_addr = '0; ha7.len = '0;
      ha7.wdata = '0;
      for (int k = 0; k < 8; k++) begin
         regs[k] = 8'($urandom);
         wq[k]   = 8'h00;
      end
      regs[1] = 8'h52;
      regs[6] = 8'h46;
      regs[7] = 8'h35;
      regs[0] = 8'h12;
      for (int k = 0; k < 8; k++) ref_regs[k] = regs[k];

      repeat (3) @(negedge clk);
      chk("rst_busy", hif.busy, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_cs", cs, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_done", hif.done, 0);
      chk("rst_err", hif.err, 0);
      chk("rst_rdata", hif.rdata, 0);
      chk("rst_rdata_valid", hif.rdata_valid, 0);
      chk("rst_wdata_take", hif.wdata_take, 0);
      rises_fl = 0;
      rst = 1'b0;
      for (int i = 0; i < 2000 && (hif.busy || ha2.busy || ha7.busy); i++) @(negedge clk);
      chk("rst_idle", hif.busy, 0);
      chk("rst_flush_rise", rises_fl, 1);
      chk("rst_no_done", ndone, 0);

      // Write A5 to ext 2 reg 1 (holding 52)
      wq[0] = 8'hA5;
      do_frame(1'b1, 3'd2, 3'd1, 0, 1'b0);
      // Read across the 7 -> 0 wrap
      do_frame(1'b0, 3'd2, 3'd6, 2, 1'b0);
      // Absent slave then a good read clearing err
      do_frame(1'b0, 3'd5, 3'd0, 0, 1'b0);
      do_frame(1'b0, 3'd2, 3'd0, 0, 1'b0);

      // rst during data bit 4 of a write
      clear_mon();
      wq[0] = 8'h3C;
      @(negedge clk);
      hif.wr = 1'b1; hif.ext_addr = 3'd2; hif.reg_addr = 3'd3; hif.len = '0; hif.start = 1'b1;
      @(negedge clk);
      hif.start = 1'b0;
      for (int i = 0; i < 5000 && rises_cs < 13; i++) @(negedge clk);
      chk("abort_reached_bit4", rises_cs, 13);
      rises_fl = 0;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_cs", cs, 0);
      chk("abort_sclk", sclk, 0);
      rst = 1'b0;
      for (int i = 0; i < 5000 && hif.busy; i++) @(negedge clk);
      chk("abort_idle", hif.busy, 0);
      chk("abort_no_rv", rvq.size(), 0);
      chk("abort_no_done", ndone, 0);
      chk("abort_flush_rises", rises_fl, 1);
      chk("abort_reg_kept", regs[3], ref_regs[3]);
      wq[0] = 8'h5A; wq[1] = 8'hC3;
      do_frame(1'b1, 3'd2, 3'd3, 1, 1'b0);

      // start while busy
      wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44;
      do_frame(1'b1, 3'd2, 3'd4, 3, 1'b1);

      // Half-period at CLK_DIV=2 and 7
      @(negedge clk);
      ha2.len = 3'd1; ha7.len = 3'd1;
      ha2.start = 1'b1; ha7.start = 1'b1;
      @(negedge clk);
      ha2.start = 1'b0; ha7.start = 1'b0;
      for (int i = 0; i < 5000 && (ha2.busy || ha7.busy); i++) @(negedge clk);
      chk("div2_min", min2, 2);
      chk("div2_max", max2, 2);
      chk("div7_min", min7, 7);
      chk("div7_max", max7, 7);

      // Randomized frames
      for (int t = 0; t < 20; t++) begin
         bit       w, mid;
         bit [2:0] e, r;
         int       n;
         w   = 1'($urandom);
         e   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(SLV_EXT);
         r   = 3'($urandom);
         n   = $urandom_range(0, 7);
         mid = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < 8; k++) wq[k] = 8'($urandom);
         do_frame(w, e, r, n, mid);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
